// File: rtl/div_iter.sv
// div_iter: iterative restoring divider, one quotient bit per cycle.
// result_o = {remainder, quotient}. A zero divisor completes in two cycles
// with div_by_zero_o set and a zero result.
// Optional feature macro: DIV_SIGNED_EN. When defined, signed_div_i selects
// two's-complement operands. When undefined, every division is unsigned and
// no negation logic is built.
module div_iter #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  input  logic               annul_i,
  input  logic               signed_div_i,
  input  logic [WIDTH-1:0]   opdata1_i,
  input  logic [WIDTH-1:0]   opdata2_i,
  output logic [2*WIDTH-1:0] result_o,
  output logic               ready_o,
  output logic               busy_o,
  output logic               div_by_zero_o
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {FREE, BYZERO, ON, END} state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] dvd;   // dividend shifting out, quotient shifting in
  logic [WIDTH-1:0] dvs;   // divisor magnitude
  logic [WIDTH-1:0] rem;   // partial remainder

  logic             accept;
  logic [WIDTH-1:0] a_abs, b_abs;
  logic [WIDTH-1:0] q_fin, r_fin;

  assign accept = (state == FREE) && start_i && !annul_i;

  // The stall request has to appear in the same cycle the request is
  // presented, so the FREE term is combinational. Reset masks it so that
  // every output reads zero while rst is held.
  assign busy_o = (state == ON) || (state == BYZERO) || (accept && !rst);

`ifdef DIV_SIGNED_EN
  logic neg_q, neg_r;
  logic a_neg, b_neg;

  assign a_neg = signed_div_i && opdata1_i[WIDTH-1];
  assign b_neg = signed_div_i && opdata2_i[WIDTH-1];
  // The most-negative value maps onto itself; read as unsigned it is the
  // correct magnitude, so MIN / -1 wraps back to MIN without special casing.
  assign a_abs = a_neg ? (~opdata1_i + 1'b1) : opdata1_i;
  assign b_abs = b_neg ? (~opdata2_i + 1'b1) : opdata2_i;
  assign q_fin = neg_q ? (~dvd + 1'b1) : dvd;
  assign r_fin = neg_r ? (~rem + 1'b1) : rem;

  // Result sign fixups, captured when the operation is accepted
  always_ff @(posedge clk) begin
    if (rst) begin
      neg_q <= 1'b0;
      neg_r <= 1'b0;
    end else if (accept) begin
      neg_q <= a_neg ^ b_neg;
      neg_r <= a_neg;
    end
  end
`else
  logic unused_sgn;

  assign unused_sgn = signed_div_i;
  assign a_abs      = opdata1_i;
  assign b_abs      = opdata2_i;
  assign q_fin      = dvd;
  assign r_fin      = rem;
`endif

  // One restoring step: shift {rem, dvd} left, trial-subtract the divisor.
  // The shifted remainder needs WIDTH+1 bits, and the extra top bit of diff
  // is the borrow.
  logic [WIDTH:0]   shl;
  logic [WIDTH+1:0] diff;
  logic             qbit;
  logic [WIDTH-1:0] rem_nx;

  // Combinational datapath for a single division step
  always_comb begin
    shl    = {rem, dvd[WIDTH-1]};
    diff   = {1'b0, shl} - {2'b00, dvs};
    qbit   = ~diff[WIDTH+1];
    rem_nx = qbit ? diff[WIDTH-1:0] : shl[WIDTH-1:0];
  end

  // Control FSM with registered result, ready and divide-by-zero flag
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= FREE;
      cnt           <= '0;
      dvd           <= '0;
      dvs           <= '0;
      rem           <= '0;
      result_o      <= '0;
      ready_o       <= 1'b0;
      div_by_zero_o <= 1'b0;
    end else begin
      case (state)
        FREE: begin
          result_o      <= '0;
          ready_o       <= 1'b0;
          div_by_zero_o <= 1'b0;
          if (accept) begin
            cnt   <= '0;
            rem   <= '0;
            dvd   <= a_abs;
            dvs   <= b_abs;
            state <= (opdata2_i == '0) ? BYZERO : ON;
          end
        end
        BYZERO: begin
          if (annul_i) begin
            state <= FREE;
          end else begin
            result_o      <= '0;
            div_by_zero_o <= 1'b1;
            ready_o       <= 1'b1;
            state         <= END;
          end
        end
        ON: begin
          if (annul_i) begin
            state <= FREE;
          end else if (cnt == CW'(WIDTH)) begin
            // Every quotient bit is in place, so apply the sign fixup and publish
            result_o <= {r_fin, q_fin};
            ready_o  <= 1'b1;
            state    <= END;
          end else begin
            rem <= rem_nx;
            dvd <= {dvd[WIDTH-2:0], qbit};
            cnt <= cnt + 1'b1;
          end
        end
        END: begin
          // Hold the result until the requester drops start_i
          if (!start_i) begin
            result_o      <= '0;
            ready_o       <= 1'b0;
            div_by_zero_o <= 1'b0;
            state         <= FREE;
          end
        end
        default: state <= FREE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_iter.sv
// tb_div_iter: table-driven checks of div_iter (WIDTH=32), plus hand-written
// sequences for zero divisor, annul, reset mid-operation and a WIDTH=8 instance.
module tb_div_iter;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, annul, sgn;
  logic [31:0] a, b;
  logic [63:0] result;
  logic        ready, busy, dbz;

  logic        start8, annul8, sgn8;
  logic [7:0]  a8, b8;
  logic [15:0] result8;
  logic        ready8, busy8, dbz8;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  div_iter #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start_i(start), .annul_i(annul),
    .signed_div_i(sgn), .opdata1_i(a), .opdata2_i(b),
    .result_o(result), .ready_o(ready), .busy_o(busy), .div_by_zero_o(dbz)
  );

  div_iter #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start_i(start8), .annul_i(annul8),
    .signed_div_i(sgn8), .opdata1_i(a8), .opdata2_i(b8),
    .result_o(result8), .ready_o(ready8), .busy_o(busy8), .div_by_zero_o(dbz8)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        s;
    logic [63:0] res;
    logic        dbz;
    int          lat;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp)
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    else
      n_pass++;
  endtask

  // Present an operation (caller is at a negedge) and count edges until ready.
  // The operands are scrambled once accepted, since they must no longer matter.
  task automatic do_op(input logic [31:0] va, input logic [31:0] vb, input logic vs,
                       output int lat);
    a = va; b = vb; sgn = vs; start = 1'b1;
    lat = 0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #1;
      lat++;
      a = $urandom; b = $urandom;
      if (ready) break;
    end
  endtask

  // Drop start and check that the divider returns to an idle, zero state
  task automatic release_op(input string name);
    @(negedge clk); start = 1'b0;
    @(posedge clk); #1;
    chk({name, "_free_ready"}, {63'd0, ready}, 64'd0);
    chk({name, "_free_result"}, result, 64'd0);
  endtask

  initial begin
    int lat;
    int bc;
    logic seen;

    rst = 1'b1; start = 1'b0; annul = 1'b0; sgn = 1'b0; a = '0; b = '0;
    start8 = 1'b0; annul8 = 1'b0; sgn8 = 1'b0; a8 = '0; b8 = '0;

    vecs.push_back('{32'd100,        32'd7,          1'b0, {32'd2, 32'd14},                 1'b0, 34});
    vecs.push_back('{32'hFFFFFFFF,   32'd1,          1'b0, {32'd0, 32'hFFFFFFFF},           1'b0, 34});
    vecs.push_back('{32'd5,          32'd10,         1'b0, {32'd5, 32'd0},                  1'b0, 34});
    vecs.push_back('{32'd12345678,   32'd0,          1'b0, 64'd0,                           1'b1, 2});
    vecs.push_back('{32'h80000000,   32'hFFFFFFFF,   1'b0, {32'h80000000, 32'd0},           1'b0, 34});
    vecs.push_back('{32'd1000000,    32'd1000,       1'b0, {32'd0, 32'd1000},               1'b0, 34});
    vecs.push_back('{32'hDEADBEEF,   32'h10,         1'b0, {32'hF, 32'h0DEADBEE},           1'b0, 34});
`ifdef DIV_SIGNED_EN
    vecs.push_back('{32'hFFFFFFF9,   32'd2,          1'b1, {32'hFFFFFFFF, 32'hFFFFFFFD},    1'b0, 34});
    vecs.push_back('{32'h80000000,   32'hFFFFFFFF,   1'b1, {32'd0, 32'h80000000},           1'b0, 34});
    vecs.push_back('{32'd7,          32'hFFFFFFFE,   1'b1, {32'd1, 32'hFFFFFFFD},           1'b0, 34});
    vecs.push_back('{32'hFFFFFFF9,   32'hFFFFFFFE,   1'b1, {32'hFFFFFFFF, 32'd3},           1'b0, 34});
`else
    // signed_div_i is ignored: operands are treated as unsigned
    vecs.push_back('{32'hFFFFFFF9,   32'd2,          1'b1, {32'd1, 32'h7FFFFFFC},           1'b0, 34});
    vecs.push_back('{32'h80000000,   32'hFFFFFFFF,   1'b1, {32'h80000000, 32'd0},           1'b0, 34});
`endif

    // Reset state, with start held high during reset
    start = 1'b1; a = 32'd9; b = 32'd3;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_result", result, 64'd0);
    chk("rst_ready",  {63'd0, ready}, 64'd0);
    chk("rst_busy",   {63'd0, busy},  64'd0);
    chk("rst_dbz",    {63'd0, dbz},   64'd0);
    @(negedge clk); start = 1'b0; rst = 1'b0;
    @(posedge clk); #1;

    // Table-driven vectors
    foreach (vecs[i]) begin
      @(negedge clk);
      do_op(vecs[i].a, vecs[i].b, vecs[i].s, lat);
      chk($sformatf("v%0d_lat", i), 64'(lat), 64'(vecs[i].lat));
      chk($sformatf("v%0d_res", i), result, vecs[i].res);
      chk($sformatf("v%0d_dbz", i), {63'd0, dbz}, {63'd0, vecs[i].dbz});
      release_op($sformatf("v%0d", i));
    end

    // Zero divisor: busy for exactly two cycles
    @(negedge clk);
    a = 32'd5; b = 32'd0; sgn = 1'b0; start = 1'b1;
    bc = 0;
    #1; if (busy) bc++;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (busy) bc++;
    end
    chk("dz_busy_cycles", 64'(bc), 64'd2);
    chk("dz_ready", {63'd0, ready}, 64'd1);
    chk("dz_flag",  {63'd0, dbz},   64'd1);
    release_op("dz");

    // annul together with start in FREE: nothing starts
    @(negedge clk);
    a = 32'd100; b = 32'd7; start = 1'b1; annul = 1'b1;
    #1;
    chk("ann_free_busy0", {63'd0, busy}, 64'd0);
    @(posedge clk); #1;
    chk("ann_free_busy1", {63'd0, busy}, 64'd0);
    @(negedge clk); start = 1'b0; annul = 1'b0;
    @(posedge clk); #1;
    chk("ann_free_busy2", {63'd0, busy}, 64'd0);

    // annul ten cycles into ON, then an immediate 9/3
    @(negedge clk);
    a = 32'd100; b = 32'd7; start = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 11; i++) begin
      @(posedge clk); #1;
      seen |= ready;
    end
    @(negedge clk); annul = 1'b1; start = 1'b0;
    @(posedge clk); #1;
    seen |= ready;
    chk("ann_on_busy",  {63'd0, busy}, 64'd0);
    chk("ann_on_ready", {63'd0, seen}, 64'd0);
    @(negedge clk); annul = 1'b0;
    do_op(32'd9, 32'd3, 1'b0, lat);
    chk("ann_next_lat", 64'(lat), 64'd34);
    chk("ann_next_res", result, {32'd0, 32'd3});
    release_op("ann_next");

    // Reset in the middle of ON, start held across reset release
    @(negedge clk);
    a = 32'd100; b = 32'd7; start = 1'b1;
    repeat (6) @(posedge clk);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    chk("mrst_result", result, 64'd0);
    chk("mrst_ready",  {63'd0, ready}, 64'd0);
    chk("mrst_busy",   {63'd0, busy},  64'd0);
    chk("mrst_dbz",    {63'd0, dbz},   64'd0);
    @(posedge clk); #1;
    chk("mrst_busy2",  {63'd0, busy},  64'd0);
    @(negedge clk); rst = 1'b0;
    do_op(32'd100, 32'd7, 1'b0, lat);
    chk("mrst_lat", 64'(lat), 64'd34);
    chk("mrst_res", result, {32'd2, 32'd14});
    release_op("mrst");

    // WIDTH=8: 255/16, then hold start in END
    @(negedge clk);
    a8 = 8'd255; b8 = 8'd16; start8 = 1'b1;
    lat = 0;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk); #1;
      lat++;
      a8 = 8'($urandom); b8 = 8'($urandom);
      if (ready8) break;
    end
    chk("w8_lat", 64'(lat), 64'd10);
    chk("w8_res", 64'(result8), 64'h0F0F);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk($sformatf("w8_hold%0d_ready", i), {63'd0, ready8}, 64'd1);
      chk($sformatf("w8_hold%0d_res", i), 64'(result8), 64'h0F0F);
    end
    @(negedge clk); start8 = 1'b0;
    @(posedge clk); #1;
    chk("w8_free_ready", {63'd0, ready8}, 64'd0);
    chk("w8_free_res",   64'(result8), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/div_iter.md
DIV_ITER -- requirements
Module: div_iter

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand width in bits (legal values 8..64).
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port start_i, input, 1 bit: request a division; level, held by the EX stage until ready_o is seen.
REQ-005 SHALL have port annul_i, input, 1 bit: abandon the in-flight division (pipeline flush).
REQ-006 SHALL have port signed_div_i, input, 1 bit: 1 = two's-complement operands, 0 = unsigned.
REQ-007 SHALL have port opdata1_i, input, WIDTH bits: dividend.
REQ-008 SHALL have port opdata2_i, input, WIDTH bits: divisor.
REQ-009 SHALL have port result_o, output, 2*WIDTH bits: {remainder, quotient}, with the remainder in the upper half (HI/LO order).
REQ-010 SHALL have port ready_o, output, 1 bit: result_o valid.
REQ-011 SHALL have port busy_o, output, 1 bit: stall request to ctrl.
REQ-012 SHALL have port div_by_zero_o, output, 1 bit: the completed result came from a zero divisor.

Function
REQ-013 SHALL implement FSM states FREE, BYZERO, ON, END.
REQ-014 FREE: when start_i=1 and annul_i=0, SHALL go to BYZERO if opdata2_i==0, else go to ON; SHALL latch the operands (absolute values if signed), clear the iteration counter and clear the partial remainder.
REQ-015 ON: SHALL perform one restoring-division step per cycle: shift {partial remainder, dividend} left 1, trial-subtract the divisor, and shift in a quotient bit of 1 if the result is non-negative, else 0.
REQ-016 ON: after WIDTH steps, SHALL sign-correct (if signed: quotient negated when operand signs differ; remainder takes the dividend's sign), go to END, and register result_o.
REQ-017 BYZERO: SHALL go to END next cycle with result_o=0 and div_by_zero_o=1.
REQ-018 END: SHALL drive ready_o=1 and hold result_o; SHALL go to FREE when start_i=0 and stay in END while start_i=1.
REQ-019 Latency SHALL be exactly WIDTH+2 cycles from start_i first sampled to ready_o=1 for a nonzero divisor, and 2 cycles for a zero divisor.
REQ-020 busy_o SHALL be 1 in BYZERO, in ON, and in FREE the cycle start_i=1 with annul_i=0; 0 otherwise.
REQ-021 annul_i=1 in BYZERO or ON SHALL force FREE next cycle, with ready_o never asserted for that operation.
REQ-022 annul_i and start_i high together in FREE: annul SHALL win and no operation starts.
REQ-023 Signed most-negative / -1 SHALL yield quotient = most-negative value (wrap) and remainder 0, with no flag.
REQ-024 Operand changes after acceptance SHALL NOT affect the in-flight result.
REQ-025 In FREE, ready_o SHALL be 0 and result_o SHALL be 0.

Reset
REQ-026 rst=1 at a clock edge SHALL force FREE, with result_o=0, ready_o=0, busy_o=0, div_by_zero_o=0, counter=0, and partial remainder=0.
REQ-027 rst SHALL take priority over start_i and annul_i in any state, including mid-ON.

Configuration
REQ-028 Macro DIV_SIGNED_EN defined: signed_div_i SHALL be honoured per REQ-014/REQ-016.
REQ-029 Macro DIV_SIGNED_EN undefined: signed_div_i SHALL be ignored, all divisions SHALL be unsigned, and no negation logic SHALL be synthesised; latency is unchanged.

Verification
REQ-030 WIDTH=32, unsigned, 100/7 -> ready_o after exactly 34 cycles, result_o={32'd2, 32'd14}.
REQ-031 WIDTH=32, signed (DIV_SIGNED_EN), -7/2 -> quotient 0xFFFFFFFD, remainder 0xFFFFFFFF; 0x80000000/0xFFFFFFFF -> quotient 0x80000000, remainder 0.
REQ-032 Divisor 0 -> ready_o after 2 cycles, div_by_zero_o=1, result_o=0, busy_o high for exactly 2 cycles.
REQ-033 annul_i pulsed 10 cycles into ON -> FREE next cycle, ready_o stays 0; a new 9/3 started immediately after -> {0, 3} after 34 cycles.
REQ-034 rst asserted mid-ON, then start_i held across reset release -> all outputs 0 during reset; a fresh division afterwards completes with correct latency.
REQ-035 WIDTH=8, unsigned, 255/16 -> ready_o after 10 cycles, result_o={8'd15, 8'd15}; start_i held high in END -> ready_o and result_o held until start_i drops.
